// File: rtl/div_pkg.sv
// Shared types and constants for the divider request controller.
package div_pkg;

  localparam int DIV_W = 32;

  localparam logic [DIV_W-1:0] DIV_Q_ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Two's-complement operand magnitudes and result sign correction.
// Only built when DIV_SIGNED_EN is defined.
`ifdef DIV_SIGNED_EN
module div_sign_fix
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] uq,
  input  logic [WIDTH-1:0] ur,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  logic a_neg;
  logic b_neg;

  assign a_neg = a[WIDTH-1];
  assign b_neg = b[WIDTH-1];

  // The most negative value maps onto itself, which is also its unsigned magnitude.
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  assign q = (a_neg ^ b_neg) ? -uq : uq;
  assign r = a_neg ? -ur : ur;

endmodule
`endif

// File: rtl/div_ctrl.sv
// Request/response wrapper around an iterative divider, one operation in flight.
// Define DIV_SIGNED_EN for two's-complement operands; unsigned otherwise.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_q,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_dz,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             busy
);

  div_state_t       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

`ifdef DIV_SIGNED_EN
  div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .a     (a_reg),
    .b     (b_reg),
    .uq    (div_q),
    .ur    (div_r),
    .mag_a (div_a),
    .mag_b (div_b),
    .q     (res_q),
    .r     (res_r)
  );
`else
  assign div_a = a_reg;
  assign div_b = b_reg;
  assign res_q = div_q;
  assign res_r = div_r;
`endif

  // Operand registers stay untouched until the next acceptance, so div_a/div_b
  // are stable across LAUNCH and WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      div_start <= 1'b0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_dz    <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            a_reg     <= req_a;
            b_reg     <= req_b;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_b == '0) begin
              state     <= RESP;
              rsp_q     <= '1;
              rsp_r     <= req_a;
              rsp_dz    <= 1'b1;
              rsp_valid <= 1'b1;
            end else begin
              state     <= LAUNCH;
              rsp_dz    <= 1'b0;
              div_start <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          // A divider still busy from before a reset is simply waited out here.
          if (div_ready) begin
            state     <= WAIT;
            div_start <= 1'b0;
          end
        end
        WAIT: begin
          if (div_ready) begin
            state     <= RESP;
            rsp_q     <= res_q;
            rsp_r     <= res_r;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: vector table plus reset/stall/back-to-back sequences,
// with a behavioural iterative divider attached. Honours DIV_SIGNED_EN.
`timescale 1ns/1ps
module tb_div_ctrl;
  import div_pkg::*;

  localparam int W = DIV_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         div_rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_q;
  logic [W-1:0] rsp_r;
  logic         rsp_dz;
  logic         div_start;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic         div_ready;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;
  logic         busy;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } rsp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  rsp_t    sb[$];
  rsp_t    exp_rsp;
  vec_t    vecs[12];
  int      checks = 0;
  int      errors = 0;
  int      start_cnt = 0;
  realtime accept_t = 0;
  realtime hs_t = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r),
    .rsp_dz    (rsp_dz),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_ready (div_ready),
    .div_q     (div_q),
    .div_r     (div_r),
    .busy      (busy)
  );

  // Divider model: result ready WIDTH+1 edges after the start edge, noise while busy.
  // It has its own reset so a controller reset leaves it running.
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  int           m_cnt;

  always @(posedge clk or posedge div_rst) begin
    if (div_rst) begin
      div_ready <= 1'b1;
      m_cnt     <= 0;
      op_a      <= '0;
      op_b      <= '0;
      div_q     <= '0;
      div_r     <= '0;
    end else if (div_ready && div_start) begin
      div_ready <= 1'b0;
      m_cnt     <= W + 1;
      op_a      <= div_a;
      op_b      <= div_b;
      div_q     <= W'($urandom);
      div_r     <= W'($urandom);
    end else if (m_cnt == 1) begin
      div_ready <= 1'b1;
      m_cnt     <= 0;
      div_q     <= (op_b == '0) ? '1 : op_a / op_b;
      div_r     <= (op_b == '0) ? op_a : op_a % op_b;
    end else if (m_cnt > 1) begin
      m_cnt     <= m_cnt - 1;
      div_q     <= W'($urandom);
      div_r     <= W'($urandom);
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare on each response handshake.
  always @(negedge clk) begin
    if (div_start) start_cnt++;
    if (!rst && rsp_valid && rsp_ready) begin
      hs_t = $realtime;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp_unexpected actual q=%h r=%h required=no response", rsp_q, rsp_r);
      end else begin
        exp_rsp = sb.pop_front();
        checkOutput("rsp_q", rsp_q, exp_rsp.q);
        checkOutput("rsp_r", rsp_r, exp_rsp.r);
        checkOutput("rsp_dz", W'(rsp_dz), W'(exp_rsp.dz));
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] q, input logic [W-1:0] r,
                               input logic dz, input bit push, input bit hold);
    int n = 0;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=not accepted required=accepted within 300 cycles");
      req_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{q: q, r: r, dz: dz});
    @(posedge clk);
    accept_t = $realtime;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic waitRspValid(output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_valid_timeout actual=0 required=1 within 200 cycles");
    end
  endtask

  task automatic waitDrain(input int max);
    int n = 0;
    while (sb.size() > 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rsp_valid"}, W'(rsp_valid), '0);
    checkOutput({tag, "_div_start"}, W'(div_start), '0);
    checkOutput({tag, "_rsp_q"}, rsp_q, '0);
    checkOutput({tag, "_rsp_r"}, rsp_r, '0);
    checkOutput({tag, "_rsp_dz"}, W'(rsp_dz), '0);
    checkOutput({tag, "_busy"}, W'(busy), '0);
  endtask

  initial begin
    int      lat;
    int      s0;
    bit      ok;
    realtime t1;

    vecs[0]  = '{a: 32'd90,  b: 32'd13, q: 32'd6,  r: 32'd12, dz: 1'b0};
    vecs[1]  = '{a: 32'd7,   b: 32'd0,  q: DIV_Q_ONES, r: 32'd7, dz: 1'b1};
    vecs[2]  = '{a: 32'd100, b: 32'd10, q: 32'd10, r: 32'd0,  dz: 1'b0};
    vecs[3]  = '{a: 32'd50,  b: 32'd7,  q: 32'd7,  r: 32'd1,  dz: 1'b0};
    vecs[4]  = '{a: 32'd0,   b: 32'd5,  q: 32'd0,  r: 32'd0,  dz: 1'b0};
    vecs[5]  = '{a: 32'd5,   b: 32'd7,  q: 32'd0,  r: 32'd5,  dz: 1'b0};
    vecs[6]  = '{a: 32'hFFFF_FFFF, b: 32'd1, q: 32'hFFFF_FFFF, r: 32'd0, dz: 1'b0};
    vecs[7]  = '{a: 32'd0,   b: 32'd0,  q: DIV_Q_ONES, r: 32'd0, dz: 1'b1};
`ifdef DIV_SIGNED_EN
    vecs[8]  = '{a: 32'hFFFF_FFF9, b: 32'd2, q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0};
    vecs[9]  = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, q: 32'h8000_0000, r: 32'd0, dz: 1'b0};
    vecs[10] = '{a: 32'd7, b: 32'hFFFF_FFFE, q: 32'hFFFF_FFFD, r: 32'd1, dz: 1'b0};
    vecs[11] = '{a: 32'hDEAD_BEEF, b: 32'd16, q: 32'hFDEA_DBEF, r: 32'hFFFF_FFFF, dz: 1'b0};
`else
    vecs[8]  = '{a: 32'hFFFF_FFF9, b: 32'd2, q: 32'h7FFF_FFFC, r: 32'd1, dz: 1'b0};
    vecs[9]  = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, q: 32'd0, r: 32'h8000_0000, dz: 1'b0};
    vecs[10] = '{a: 32'd7, b: 32'hFFFF_FFFE, q: 32'd0, r: 32'd7, dz: 1'b0};
    vecs[11] = '{a: 32'hDEAD_BEEF, b: 32'd16, q: 32'h0DEA_DBEE, r: 32'd15, dz: 1'b0};
`endif

    rst       = 1'b1;
    div_rst   = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst     = 1'b0;
    div_rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_req_ready", W'(req_ready), W'(1'b1));
    checkOutput("idle_busy", W'(busy), '0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b1, 1'b0);
      waitDrain(100);
    end

    // Normal latency and busy flag while in flight.
    applyStimulus(32'd90, 32'd13, 32'd6, 32'd12, 1'b0, 1'b1, 1'b0);
    checkOutput("inflight_busy", W'(busy), W'(1'b1));
    checkOutput("inflight_req_ready", W'(req_ready), '0);
    waitRspValid(lat);
    checks++;
    if (lat < W || lat > 40) begin
      errors++;
      $display("[TB] FAIL latency actual=%0d required=%0d..40", lat, W);
    end
    waitDrain(10);

    // Divide by zero: response on the next cycle, divider never started.
    s0 = start_cnt;
    applyStimulus(32'd7, 32'd0, DIV_Q_ONES, 32'd7, 1'b1, 1'b1, 1'b0);
    checkOutput("dz_rsp_next_cycle", W'(rsp_valid), W'(1'b1));
    waitDrain(10);
    checkOutput("dz_no_div_start", W'(start_cnt), W'(s0));

    // Stalled response held stable for 20 cycles.
    rsp_ready = 1'b0;
    applyStimulus(32'd100, 32'd10, 32'd10, 32'd0, 1'b0, 1'b1, 1'b0);
    waitRspValid(lat);
    ok = 1'b1;
    repeat (20) begin
      if (rsp_q !== 32'd10 || rsp_r !== 32'd0 || rsp_valid !== 1'b1 || req_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("stall_stable", W'(ok), W'(1'b1));
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("stall_idle_busy", W'(busy), '0);
    checkOutput("stall_idle_req_ready", W'(req_ready), W'(1'b1));
    waitDrain(5);

    // Reset while waiting on the divider; next request must see fresh results.
    applyStimulus(32'd200, 32'd3, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetOutputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(32'd50, 32'd7, 32'd7, 32'd1, 1'b0, 1'b1, 1'b0);
    waitDrain(300);

    // Reset with a pending response drops it for good.
    rsp_ready = 1'b0;
    applyStimulus(32'd9, 32'd2, '0, '0, 1'b0, 1'b0, 1'b0);
    waitRspValid(lat);
    rst = 1'b1;
    #1;
    checkOutput("rst_drops_rsp", W'(rsp_valid), '0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("rst_no_reissue", W'(rsp_valid), '0);

    // Back-to-back with req_valid held high.
    applyStimulus(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b1, 1'b1);
    t1 = accept_t;
    applyStimulus(32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (!(hs_t > t1 && accept_t > hs_t)) begin
      errors++;
      $display("[TB] FAIL b2b_order actual accept2=%0t hs1=%0t required accept2 after hs1", accept_t, hs_t);
    end
    waitDrain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
